reservoir_spike_readout: RTL and testbench
==========================================

Name: reservoir_spike_readout

Overview:
- Downstream stage of Reservoir_crossbar. Consumes the 16-bit spike_record vector once per reservoir time step.
- Keeps one saturating spike counter per neuron over a fixed window of WINDOW steps.
- At the end of each window it snapshots all counts into a shadow bank and restarts counting. The shadow bank is then streamed out one neuron per beat over a valid/ready interface for the readout/classifier layer.

Parameters:
- N_NEURONS, 16, number of reservoir neurons (width of spike_record).
- WINDOW, 64, time steps per integration window (>=2).
- CNT_W, 8, counter width; counts saturate at 2^CNT_W-1.
- IDX_W, 4, width of out_index (clog2 of N_NEURONS).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear: empties live counters, step counter and shadow, aborts drain.
- enable  in  1  when low, step_valid is ignored.
- step_valid  in  1  one-cycle strobe: spike_record holds a valid time step.
- spike_record  in  [0:N_NEURONS-1]  reservoir spikes; bit i = neuron i.
- out_valid  out  1  a shadow count is presented.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  IDX_W  neuron index of the current beat.
- out_count  out  CNT_W  spike count of neuron out_index.
- out_last  out  1  high on the beat with out_index = N_NEURONS-1.
- window_done  out  1  one-cycle pulse when a window closes.
- overrun  out  1  sticky; a window closed while the drain was still busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - All live counters, shadow bank, step counter and index go to 0.
  - out_valid, out_last, window_done and overrun go to 0.
  - FSM goes to ACCUM.
- Accumulate (any state, enable=1, step_valid=1):
  - Each live counter i becomes cnt[i] + spike_record[i], saturating at 2^CNT_W-1.
  - The step counter increments.
- Window close: a step_valid arrives with step counter = WINDOW-1.
  - That step is included in the counts.
  - If the drain is idle, the live counts are copied into the shadow bank.
  - Live counters and the step counter clear to 0. This happens even when the snapshot is dropped.
  - window_done pulses on the next cycle.
- FSM has two states, ACCUM and DRAIN. Accumulation continues in both.
  - ACCUM -> DRAIN on a window close. Next cycle: out_valid=1, out_index=0, out_count=shadow[0]. Latency is 1 cycle from the closing step_valid.
  - In DRAIN, out_index, out_count and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, out_index increments.
  - On the handshake with out_last=1: go to ACCUM and set out_valid=0 on the next cycle.
- Window close while in DRAIN (before the last beat's handshake):
  - The snapshot is dropped, the shadow bank is untouched and overrun is set (sticky).
  - The drain continues unchanged.
  - overrun clears only by reset or clear.
- Last-beat handshake in the same cycle as a window close:
  - The handshake completes, the new snapshot is loaded and no overrun is flagged.
  - Next cycle: out_valid stays 1 with out_index=0.
- enable=0: step_valid is ignored and counters hold. An in-progress drain still proceeds.
- clear=1: has priority over everything in the same cycle.
  - Live counters, shadow bank, step counter and index go to 0.
  - out_valid=0 and overrun=0; FSM goes to ACCUM.
  - The step_valid of that cycle is discarded.
- out_count is a registered read of shadow[out_index]. It carries no combinational path from spike_record.

Decomposition:
- Shared package holds:
  - Default constants N_NEURONS=16, CNT_W=8, WINDOW=64.
  - The readout FSM state enum (ACCUM, DRAIN).
  - The beat-record type {index, count, last}.
- One sub-module: spike_sat_counter (a single CNT_W saturating counter with clear and increment enable), instantiated N_NEURONS times.
- Shadow bank and drain FSM stay in the top module.

Test Plan:
- Basic window: WINDOW=4, enable=1, 4 steps of spike_record=16'b1011110111110110, out_ready=1.
  - Required: window_done pulses one cycle after step 4.
  - 16 beats: count=4 for neurons 0,2,3,4,5,7,8,9,10,11,13,14; count=0 for neurons 1,6,12,15.
  - out_last on index 15; then out_valid=0.
- Saturation: CNT_W=3, WINDOW=10, spike_record all ones for 10 steps -> every out_count=7.
- Backpressure: hold out_ready=0 for 5 cycles at index 3 -> out_index=3 and out_count stay stable; index 4 follows one cycle after out_ready rises.
- Overrun: WINDOW=4, out_ready=0 through a second window close -> overrun=1; shadow still returns the first window's counts; live counters restart at 0.
- Edge coincidence: time the last-beat handshake in the same cycle as a window close -> overrun stays 0; next cycle out_valid=1, out_index=0, and the new counts are presented.
- Reset/clear mid-drain: assert reset=0 asynchronously, then separately clear=1 at index 7 -> both return all outputs to 0 and ACCUM. The next window counts from 0.

Source files
------------

// File: rtl/reservoir_spike_readout_pkg.sv
// Shared constants and types for the reservoir spike readout stage.
//   DEF_*      : default parameter values for the readout top.
//   rd_state_e : drain FSM state (ACCUM, DRAIN).
//   beat_t     : one output beat {index, count, last} at the default widths.
package reservoir_spike_readout_pkg;

    localparam int unsigned DEF_N_NEURONS = 16;
    localparam int unsigned DEF_WINDOW    = 64;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_IDX_W     = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] index;
        logic [DEF_CNT_W-1:0] count;
        logic                 last;
    } beat_t;

endpackage

// File: rtl/reservoir_spike_readout_if.sv
// Valid/ready beat stream carrying one neuron's window count per beat.
//   out_valid : a shadow count is presented
//   out_ready : consumer accepts the beat
//   out_index : neuron index of the beat
//   out_count : spike count of that neuron
//   out_last  : beat of the highest neuron index
interface reservoir_spike_readout_if
    import reservoir_spike_readout_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport master (
        output out_valid,
        output out_index,
        output out_count,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_count,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reservoir_spike_readout_sat_counter.sv
// Single saturating spike counter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : add one this cycle, saturating at all-ones
//   cnt_upd_c  : count including this cycle's increment, before any clear;
//                this is the value a window snapshot must capture
module spike_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_upd_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating increment, then optional clear.
    always_comb begin
        cnt_upd_c = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_upd_c = cnt_q + CNT_W'(1);
        end
        cnt_d = clr_i ? '0 : cnt_upd_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reservoir_spike_readout.sv
// Windowed spike-count readout for the reservoir crossbar.
// Counts spikes per neuron over WINDOW valid steps, snapshots the counts
// into a shadow bank at window close and streams the shadow bank out one
// neuron per beat.
//   clk, rst_n      : clock, async active-low reset
//   clear_i         : synchronous clear of counters, shadow, drain, overrun
//   enable_i        : gates step_valid_i
//   step_valid_i    : spike_record_i holds a valid time step
//   spike_record_i  : bit i = neuron i fired
//   rd              : beat stream (master side)
//   window_done_o   : one-cycle pulse after a window closes
//   overrun_o       : sticky, a window closed while the drain was busy
module reservoir_spike_readout
    import reservoir_spike_readout_pkg::*;
#(
    parameter int unsigned N_NEURONS = DEF_N_NEURONS,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned IDX_W     = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 step_valid_i,
    input  logic [0:N_NEURONS-1] spike_record_i,
    reservoir_spike_readout_if.master rd,
    output logic                 window_done_o,
    output logic                 overrun_o
);

    localparam int unsigned      STEP_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_NEURONS - 1);

    rd_state_e        state_q, state_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q, last_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic             wdone_q, wdone_d;
    logic             ovr_q, ovr_d;

    logic [CNT_W-1:0] shadow_q [N_NEURONS];
    logic [CNT_W-1:0] live_upd [N_NEURONS];

    logic             step_fire;
    logic             win_close;
    logic             hs;
    logic             last_hs;
    logic             drain_idle;
    logic             snap;
    logic [IDX_W-1:0] idx_inc;

    assign step_fire  = enable_i & step_valid_i & ~clear_i;
    assign win_close  = step_fire & (step_q == STEP_LAST);
    assign hs         = valid_q & rd.out_ready;
    assign last_hs    = hs & last_q;
    // The shadow bank is free if nothing is draining or the final beat leaves now.
    assign drain_idle = (state_q == ACCUM) | last_hs;
    assign snap       = win_close & drain_idle;
    assign idx_inc    = idx_q + IDX_W'(1);

    // Live counters; cleared at every window close whether or not the snapshot is taken.
    for (genvar i = 0; i < int'(N_NEURONS); i++) begin : g_cnt
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (clear_i | win_close),
            .inc_i     (step_fire & spike_record_i[i]),
            .cnt_upd_c (live_upd[i])
        );
    end

    // Step counter within the current window.
    always_comb begin
        step_d = step_q;
        if (clear_i || win_close) begin
            step_d = '0;
        end else if (step_fire) begin
            step_d = step_q + STEP_W'(1);
        end
    end

    // Shadow bank: loaded only when the drain can accept a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                shadow_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                shadow_q[i] <= live_upd[i];
            end
        end
    end

    // Drain FSM next-state and beat registers. The first beat of a new window
    // reads the snapshot source directly, since the shadow bank loads the same edge.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        count_d = count_q;
        last_d  = last_q;
        wdone_d = win_close;
        ovr_d   = ovr_q | (win_close & ~drain_idle);

        case (state_q)
            ACCUM: begin
                if (snap) begin
                    state_d = DRAIN;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    count_d = live_upd[0];
                    last_d  = (IDX_LAST == '0);
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (last_q) begin
                        if (snap) begin
                            idx_d   = '0;
                            count_d = live_upd[0];
                            last_d  = (IDX_LAST == '0);
                        end else begin
                            state_d = ACCUM;
                            valid_d = 1'b0;
                            idx_d   = '0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_inc;
                        count_d = shadow_q[idx_inc];
                        last_d  = (idx_inc == IDX_LAST);
                    end
                end
            end
            default: ;
        endcase

        if (clear_i) begin
            state_d = ACCUM;
            valid_d = 1'b0;
            idx_d   = '0;
            count_d = '0;
            last_d  = 1'b0;
            wdone_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            valid_q <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            step_q  <= '0;
            wdone_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            last_q  <= last_d;
            step_q  <= step_d;
            wdone_q <= wdone_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd.out_valid  = valid_q;
    assign rd.out_index  = idx_q;
    assign rd.out_count  = count_q;
    assign rd.out_last   = last_q;
    assign window_done_o = wdone_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_reservoir_spike_readout.sv
// Self-checking bench for reservoir_spike_readout: one instance with a short
// window for the protocol scenarios, one with a narrow counter for saturation.
module tb_reservoir_spike_readout;
    import reservoir_spike_readout_pkg::*;

    localparam int unsigned NN = 16;
    localparam int unsigned WA = 4;
    localparam int unsigned CA = 8;
    localparam int unsigned WS = 10;
    localparam int unsigned CS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          clear_a = 1'b0, enable_a = 1'b0, sv_a = 1'b0;
    logic [0:NN-1] spike_a = '0;
    logic          wd_a, ovr_a;

    logic          clear_s = 1'b0, enable_s = 1'b0, sv_s = 1'b0;
    logic [0:NN-1] spike_s = '0;
    logic          wd_s, ovr_s;

    reservoir_spike_readout_if #(.IDX_W(4), .CNT_W(CA)) ifa ();
    reservoir_spike_readout_if #(.IDX_W(4), .CNT_W(CS)) ifs ();

    reservoir_spike_readout #(.N_NEURONS(NN), .WINDOW(WA), .CNT_W(CA), .IDX_W(4)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_a),
        .enable_i       (enable_a),
        .step_valid_i   (sv_a),
        .spike_record_i (spike_a),
        .rd             (ifa.master),
        .window_done_o  (wd_a),
        .overrun_o      (ovr_a)
    );

    reservoir_spike_readout #(.N_NEURONS(NN), .WINDOW(WS), .CNT_W(CS), .IDX_W(4)) dut_s (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_s),
        .enable_i       (enable_s),
        .step_valid_i   (sv_s),
        .spike_record_i (spike_s),
        .rd             (ifs.master),
        .window_done_o  (wd_s),
        .overrun_o      (ovr_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: live counts, step position, queue of beats still to deliver.
    int    live [NN];
    int    steps;
    beat_t expq [$];
    bit    exp_ovr;
    bit    exp_wd;

    task automatic model_reset();
        foreach (live[i]) live[i] = 0;
        steps   = 0;
        expq.delete();
        exp_ovr = 1'b0;
        exp_wd  = 1'b0;
    endtask

    // Drive one cycle of inputs at a falling edge, advance to the next falling edge, update model.
    task automatic tick(input bit en, input bit sv, input logic [0:NN-1] sp, input bit rdy, input bit clr);
        bit fire;
        bit close;
        enable_a      = en;
        sv_a          = sv;
        spike_a       = sp;
        ifa.out_ready = rdy;
        clear_a       = clr;
        @(negedge clk);
        if (clr) begin
            model_reset();
        end else begin
            fire  = en && sv;
            close = fire && (steps == int'(WA) - 1);
            if (expq.size() > 0 && rdy) void'(expq.pop_front());
            if (fire) foreach (live[i]) if (sp[i] && live[i] < (1 << CA) - 1) live[i]++;
            if (close) begin
                if (expq.size() == 0) begin
                    for (int i = 0; i < int'(NN); i++)
                        expq.push_back(beat_t'{index: 4'(i), count: 8'(live[i]), last: (i == int'(NN) - 1)});
                end else begin
                    exp_ovr = 1'b1;
                end
                foreach (live[i]) live[i] = 0;
                steps = 0;
            end else if (fire) begin
                steps++;
            end
            exp_wd = close;
        end
    endtask

    function automatic logic [0:NN-1] rnd_spikes();
        return NN'($urandom);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", ifa.out_valid); end
        n_checks++; if (ifa.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b exp 0", ifa.out_last); end
        n_checks++; if (ifa.out_index !== 4'd0) begin n_fail++; $display("FAIL reset_index got %0d exp 0", ifa.out_index); end
        n_checks++; if (ifa.out_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", ifa.out_count); end
        n_checks++; if (wd_a !== 1'b0) begin n_fail++; $display("FAIL reset_wdone got %0b exp 0", wd_a); end
        n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b exp 0", ovr_a); end
        n_checks++; if (ifs.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s got %0b exp 0", ifs.out_valid); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [0:NN-1] pat;
        int expc;
        pat = 16'b1011110111110110;
        for (int s = 0; s < int'(WA); s++) begin
            tick(1, 1, pat, 1, 0);
            if (s == int'(WA) - 2) begin
                n_checks++; if (wd_a !== 1'b0) begin n_fail++; $display("FAIL basic_early_wdone got %0b exp 0", wd_a); end
            end
        end
        n_checks++; if (wd_a !== 1'b1) begin n_fail++; $display("FAIL basic_wdone got %0b exp 1", wd_a); end
        n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b exp 1", ifa.out_valid); end
        for (int i = 0; i < int'(NN); i++) begin
            expc = pat[i] ? int'(WA) : 0;
            n_checks++; if (ifa.out_index !== 4'(i)) begin n_fail++; $display("FAIL basic_index got %0d exp %0d", ifa.out_index, i); end
            n_checks++; if (ifa.out_count !== 8'(expc)) begin n_fail++; $display("FAIL basic_count[%0d] got %0d exp %0d", i, ifa.out_count, expc); end
            n_checks++; if (ifa.out_last !== (i == int'(NN) - 1)) begin n_fail++; $display("FAIL basic_last[%0d] got %0b", i, ifa.out_last); end
            tick(1, 0, '0, 1, 0);
            if (i == 0) begin
                n_checks++; if (wd_a !== 1'b0) begin n_fail++; $display("FAIL basic_wdone_pulse got %0b exp 0", wd_a); end
            end
        end
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %0b exp 0", ifa.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        for (int s = 0; s < int'(WA); s++) tick(1, 1, rnd_spikes(), 0, 0);
        for (int k = 0; k < 3; k++) tick(1, 0, '0, 1, 0);
        held = expq[0].count;
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, '0, 0, 0);
            n_checks++; if (ifa.out_index !== 4'd3) begin n_fail++; $display("FAIL bp_index_hold got %0d exp 3", ifa.out_index); end
            n_checks++; if (ifa.out_count !== held) begin n_fail++; $display("FAIL bp_count_hold got %0d exp %0d", ifa.out_count, held); end
        end
        tick(1, 0, '0, 1, 0);
        n_checks++; if (ifa.out_index !== 4'd4) begin n_fail++; $display("FAIL bp_index_next got %0d exp 4", ifa.out_index); end
        n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL bp_count_next got %0d exp %0d", ifa.out_count, expq[0].count); end
        for (int k = 0; k < 40 && expq.size() > 0; k++) tick(1, 0, '0, 1, 0);
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got %0b exp 0", ifa.out_valid); end
    endtask

    task automatic test_overrun();
        for (int s = 0; s < 2 * int'(WA); s++) tick(1, 1, rnd_spikes(), 0, 0);
        n_checks++; if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b exp 1", ovr_a); end
        n_checks++; if (ifa.out_index !== 4'd0) begin n_fail++; $display("FAIL ovr_index got %0d exp 0", ifa.out_index); end
        for (int k = 0; k < int'(NN); k++) begin
            n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL ovr_first_window[%0d] got %0d exp %0d", k, ifa.out_count, expq[0].count); end
            tick(1, 0, '0, 1, 0);
        end
        n_checks++; if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %0b exp 1", ovr_a); end
        for (int s = 0; s < int'(WA); s++) tick(1, 1, rnd_spikes(), 0, 0);
        for (int k = 0; k < int'(NN); k++) begin
            n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL ovr_restart[%0d] got %0d exp %0d", k, ifa.out_count, expq[0].count); end
            tick(1, 0, '0, 1, 0);
        end
        tick(1, 0, '0, 0, 1);
        n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b exp 0", ovr_a); end
    endtask

    task automatic test_coincide();
        for (int s = 0; s < int'(WA); s++) tick(1, 1, rnd_spikes(), 1, 0);
        for (int k = 0; k < int'(NN) - 1; k++) tick(1, k < int'(WA) - 1, rnd_spikes(), 1, 0);
        n_checks++; if (ifa.out_last !== 1'b1) begin n_fail++; $display("FAIL co_last got %0b exp 1", ifa.out_last); end
        tick(1, 1, rnd_spikes(), 1, 0);
        n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL co_overrun got %0b exp 0", ovr_a); end
        n_checks++; if (wd_a !== 1'b1) begin n_fail++; $display("FAIL co_wdone got %0b exp 1", wd_a); end
        n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL co_valid got %0b exp 1", ifa.out_valid); end
        n_checks++; if (ifa.out_index !== 4'd0) begin n_fail++; $display("FAIL co_index got %0d exp 0", ifa.out_index); end
        for (int k = 0; k < int'(NN); k++) begin
            n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL co_count[%0d] got %0d exp %0d", k, ifa.out_count, expq[0].count); end
            tick(1, 0, '0, 1, 0);
        end
    endtask

    task automatic test_reset_clear();
        // Async reset mid-drain with overrun set
        for (int s = 0; s < 2 * int'(WA); s++) tick(1, 1, rnd_spikes(), 0, 0);
        for (int k = 0; k < 7; k++) tick(1, 0, '0, 1, 0);
        n_checks++; if (ifa.out_index !== 4'd7) begin n_fail++; $display("FAIL rc_pre_index got %0d exp 7", ifa.out_index); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %0b exp 0", ifa.out_valid); end
        n_checks++; if (ifa.out_index !== 4'd0) begin n_fail++; $display("FAIL rst_async_index got %0d exp 0", ifa.out_index); end
        n_checks++; if (ifa.out_count !== 8'd0) begin n_fail++; $display("FAIL rst_async_count got %0d exp 0", ifa.out_count); end
        n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_overrun got %0b exp 0", ovr_a); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Synchronous clear mid-drain, with a step offered in the same cycle
        for (int s = 0; s < 2 * int'(WA); s++) tick(1, 1, rnd_spikes(), 0, 0);
        for (int k = 0; k < 7; k++) tick(1, 0, '0, 1, 0);
        tick(1, 1, '1, 1, 1);
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0b exp 0", ifa.out_valid); end
        n_checks++; if (ifa.out_index !== 4'd0) begin n_fail++; $display("FAIL clr_index got %0d exp 0", ifa.out_index); end
        n_checks++; if (ifa.out_count !== 8'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", ifa.out_count); end
        n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL clr_overrun got %0b exp 0", ovr_a); end
        for (int s = 0; s < int'(WA) - 1; s++) tick(1, 1, rnd_spikes(), 1, 0);
        n_checks++; if (wd_a !== 1'b0) begin n_fail++; $display("FAIL clr_step_restart got %0b exp 0", wd_a); end
        tick(1, 1, rnd_spikes(), 1, 0);
        n_checks++; if (wd_a !== 1'b1) begin n_fail++; $display("FAIL clr_wdone got %0b exp 1", wd_a); end
        for (int k = 0; k < int'(NN); k++) begin
            n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL clr_next_window[%0d] got %0d exp %0d", k, ifa.out_count, expq[0].count); end
            tick(1, 0, '0, 1, 0);
        end
    endtask

    task automatic test_saturation();
        int cap;
        int exp_sat;
        cap     = (1 << CS) - 1;
        exp_sat = (int'(WS) < cap) ? int'(WS) : cap;
        enable_s      = 1'b1;
        spike_s       = '1;
        ifs.out_ready = 1'b1;
        sv_s          = 1'b1;
        repeat (WS - 1) @(negedge clk);
        n_checks++; if (wd_s !== 1'b0) begin n_fail++; $display("FAIL sat_early_wdone got %0b exp 0", wd_s); end
        @(negedge clk);
        sv_s = 1'b0;
        n_checks++; if (wd_s !== 1'b1) begin n_fail++; $display("FAIL sat_wdone got %0b exp 1", wd_s); end
        for (int i = 0; i < int'(NN); i++) begin
            n_checks++; if (ifs.out_index !== 4'(i)) begin n_fail++; $display("FAIL sat_index got %0d exp %0d", ifs.out_index, i); end
            n_checks++; if (ifs.out_count !== 3'(exp_sat)) begin n_fail++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, ifs.out_count, exp_sat); end
            @(negedge clk);
        end
        n_checks++; if (ifs.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_end_valid got %0b exp 0", ifs.out_valid); end
    endtask

    task automatic test_random();
        bit en, sv, rdy, clr;
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom % 8) != 0;
            sv  = ($urandom % 2) != 0;
            rdy = ($urandom % 4) != 0;
            clr = ($urandom % 97) == 0;
            tick(en, sv, rnd_spikes(), rdy, clr);
            n_checks++; if (ifa.out_valid !== (expq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", c, ifa.out_valid, expq.size() > 0); end
            n_checks++; if (wd_a !== exp_wd) begin n_fail++; $display("FAIL rnd_wdone cyc %0d got %0b exp %0b", c, wd_a, exp_wd); end
            n_checks++; if (ovr_a !== exp_ovr) begin n_fail++; $display("FAIL rnd_overrun cyc %0d got %0b exp %0b", c, ovr_a, exp_ovr); end
            if (expq.size() > 0) begin
                n_checks++; if (ifa.out_index !== expq[0].index) begin n_fail++; $display("FAIL rnd_index cyc %0d got %0d exp %0d", c, ifa.out_index, expq[0].index); end
                n_checks++; if (ifa.out_count !== expq[0].count) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, ifa.out_count, expq[0].count); end
                n_checks++; if (ifa.out_last !== expq[0].last) begin n_fail++; $display("FAIL rnd_last cyc %0d got %0b exp %0b", c, ifa.out_last, expq[0].last); end
            end
        end
    endtask

    initial begin
        ifa.out_ready = 1'b0;
        ifs.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_coincide();
        test_reset_clear();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
